// File: rtl/ren_bin_walker_pkg.sv
// Shared definitions for the setup-to-binner tile walker: screen defaults,
// record field widths and the walker state encoding.
package ren_bin_walker_pkg;

    localparam int NUM_TILES_X_DEF = 40;
    localparam int NUM_TILES_Y_DEF = 30;
    localparam int TILE_SIZE       = 16;
    localparam int COORD_W         = 16;
    localparam int END_W           = COORD_W + 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        s_IDLE = 2'd0,
        s_CLIP = 2'd1,
        s_WALK = 2'd2
    } walk_state_t;

endpackage

// File: rtl/ren_bin_walker_if.sv
// Triangle-queue read side and bin-entry output side of the tile walker.
interface ren_bin_walker_if #(
    parameter int TRI_ID_W = 12
);
    import ren_bin_walker_pkg::*;

    logic                i_fifo_empty;
    logic                o_fifo_rd;
    coord_t              i_tile_x0;
    coord_t              i_tile_y0;
    coord_t              i_steps_x;
    coord_t              i_steps_y;
    logic                o_valid;
    logic                i_ready;
    coord_t              o_tile_x;
    coord_t              o_tile_y;
    logic [TRI_ID_W-1:0] o_tri_id;
    logic                o_last;
    logic                o_reject;
    logic                o_idle;

    modport master (
        input  i_fifo_empty, i_tile_x0, i_tile_y0, i_steps_x, i_steps_y, i_ready,
        output o_fifo_rd, o_valid, o_tile_x, o_tile_y, o_tri_id, o_last, o_reject, o_idle
    );

    modport slave (
        output i_fifo_empty, i_tile_x0, i_tile_y0, i_steps_x, i_steps_y, i_ready,
        input  o_fifo_rd, o_valid, o_tile_x, o_tile_y, o_tri_id, o_last, o_reject, o_idle
    );

endinterface

// File: rtl/ren_bin_walker_tile_clamp.sv
// One axis of the tile rectangle: base + step summed without wrap, clamped to
// the last on-screen tile, with a flag when the base itself is off-screen.
module ren_bin_walker_tile_clamp
    import ren_bin_walker_pkg::*;
#(
    parameter int LIMIT = 40
) (
    input  coord_t i_base,
    input  coord_t i_step,
    output coord_t o_end,
    output logic   o_off
);

    localparam logic [END_W-1:0] LAST = END_W'(LIMIT - 1);

    logic [END_W-1:0] end_full;

    always_comb begin
        end_full = {1'b0, i_base} + {1'b0, i_step};
        o_off    = {1'b0, i_base} > LAST;
        o_end    = (end_full > LAST) ? LAST[COORD_W-1:0] : end_full[COORD_W-1:0];
    end

endmodule

// File: rtl/ren_bin_walker.sv
// Pops triangle tile rectangles from the setup queue, clips them to the screen
// and emits one bin entry per covered tile in row-major order.
module ren_bin_walker
    import ren_bin_walker_pkg::*;
#(
    parameter int NUM_TILES_X = NUM_TILES_X_DEF,
    parameter int NUM_TILES_Y = NUM_TILES_Y_DEF,
    parameter int TRI_ID_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    ren_bin_walker_if.master  bus
);

    walk_state_t         state_q, state_d;
    coord_t              x0_q, x0_d, y0_q, y0_d;
    coord_t              sx_q, sx_d, sy_q, sy_d;
    coord_t              end_x_q, end_x_d, end_y_q, end_y_d;
    coord_t              cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [TRI_ID_W-1:0] tri_id_q, tri_id_d;

    coord_t clamp_x, clamp_y;
    logic   off_x, off_y;
    logic   at_end_x, at_end_y;

    ren_bin_walker_tile_clamp #(.LIMIT(NUM_TILES_X)) u_clamp_x (
        .i_base (x0_q),
        .i_step (sx_q),
        .o_end  (clamp_x),
        .o_off  (off_x)
    );

    ren_bin_walker_tile_clamp #(.LIMIT(NUM_TILES_Y)) u_clamp_y (
        .i_base (y0_q),
        .i_step (sy_q),
        .o_end  (clamp_y),
        .o_off  (off_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= s_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            tri_id_q <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            end_x_q  <= end_x_d;
            end_y_q  <= end_y_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            tri_id_q <= tri_id_d;
        end
    end

    assign at_end_x = (cur_x_q == end_x_q);
    assign at_end_y = (cur_y_q == end_y_q);

    always_comb begin
        state_d       = state_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        end_x_d       = end_x_q;
        end_y_d       = end_y_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        tri_id_d      = tri_id_q;
        bus.o_fifo_rd = 1'b0;
        bus.o_valid   = 1'b0;
        bus.o_last    = 1'b0;
        bus.o_reject  = 1'b0;
        bus.o_idle    = 1'b0;

        case (state_q)
            s_IDLE: begin
                bus.o_idle = 1'b1;
                // Gate the pop with rst so nothing is consumed while held in reset.
                if (!bus.i_fifo_empty && !rst) begin
                    bus.o_fifo_rd = 1'b1;
                    x0_d          = bus.i_tile_x0;
                    y0_d          = bus.i_tile_y0;
                    sx_d          = bus.i_steps_x;
                    sy_d          = bus.i_steps_y;
                    state_d       = s_CLIP;
                end
            end
            s_CLIP: begin
                if (off_x || off_y) begin
                    bus.o_reject = 1'b1;
                    tri_id_d     = tri_id_q + 1'b1;
                    state_d      = s_IDLE;
                end else begin
                    end_x_d = clamp_x;
                    end_y_d = clamp_y;
                    cur_x_d = x0_q;
                    cur_y_d = y0_q;
                    state_d = s_WALK;
                end
            end
            s_WALK: begin
                bus.o_valid = 1'b1;
                bus.o_last  = at_end_x && at_end_y;
                if (bus.i_ready) begin
                    if (!at_end_x) begin
                        cur_x_d = cur_x_q + 1'b1;
                    end else if (!at_end_y) begin
                        cur_x_d = x0_q;
                        cur_y_d = cur_y_q + 1'b1;
                    end else begin
                        tri_id_d = tri_id_q + 1'b1;
                        state_d  = s_IDLE;
                    end
                end
            end
            default: state_d = s_IDLE;
        endcase
    end

    assign bus.o_tile_x = cur_x_q;
    assign bus.o_tile_y = cur_y_q;
    assign bus.o_tri_id = tri_id_q;

endmodule

// File: tb/tb_ren_bin_walker.sv
// Bench for ren_bin_walker: a queue-fed reference model expands each popped
// record into its expected bin entries and a negedge process compares every cycle.
module tb_ren_bin_walker;
    import ren_bin_walker_pkg::*;

    localparam int NX = 20;
    localparam int NY = 30;
    localparam int TW = 2;

    typedef struct {
        int x0;
        int y0;
        int sx;
        int sy;
    } rec_t;

    typedef struct {
        bit is_rej;
        int x;
        int y;
        int id;
        bit last;
        bit first;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ren_bin_walker_if #(.TRI_ID_W(TW)) bus ();

    ren_bin_walker #(
        .NUM_TILES_X (NX),
        .NUM_TILES_Y (NY),
        .TRI_ID_W    (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rec_t fifo_q[$];
    ent_t exp_q[$];
    int   beat_x[$], beat_y[$], beat_id[$], beat_last[$];
    int   rej_ids[$];
    int   pop_log[$];
    int   t5_ids[6] = '{0, 1, 2, 3, 0, 1};

    int vectors    = 0;
    int errors     = 0;
    int cyc        = 0;
    int pop_cyc    = 0;
    int model_id   = 0;
    int ready_mode = 0;
    bit pop_flag   = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expand the head record into the entries the walker must produce.
    task automatic model_pop();
        rec_t r;
        ent_t e;
        int   ex, ey;
        if (fifo_q.size() == 0) return;
        r = fifo_q[0];
        if (r.x0 >= NX || r.y0 >= NY) begin
            e.is_rej = 1'b1; e.x = 0; e.y = 0; e.id = model_id; e.last = 1'b0; e.first = 1'b0;
            exp_q.push_back(e);
        end else begin
            ex = (r.x0 + r.sx < NX - 1) ? r.x0 + r.sx : NX - 1;
            ey = (r.y0 + r.sy < NY - 1) ? r.y0 + r.sy : NY - 1;
            for (int y = r.y0; y <= ey; y++) begin
                for (int x = r.x0; x <= ex; x++) begin
                    e.is_rej = 1'b0;
                    e.x      = x;
                    e.y      = y;
                    e.id     = model_id;
                    e.last   = (x == ex) && (y == ey);
                    e.first  = (x == r.x0) && (y == r.y0);
                    exp_q.push_back(e);
                end
            end
        end
        model_id = (model_id + 1) % (1 << TW);
    endtask

    task automatic drive_fifo();
        if (fifo_q.size() == 0) begin
            bus.i_fifo_empty = 1'b1;
            bus.i_tile_x0    = '0;
            bus.i_tile_y0    = '0;
            bus.i_steps_x    = '0;
            bus.i_steps_y    = '0;
        end else begin
            bus.i_fifo_empty = 1'b0;
            bus.i_tile_x0    = 16'(fifo_q[0].x0);
            bus.i_tile_y0    = 16'(fifo_q[0].y0);
            bus.i_steps_x    = 16'(fifo_q[0].sx);
            bus.i_steps_y    = 16'(fifo_q[0].sy);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_flag) begin
            pop_flag = 1'b0;
            if (fifo_q.size() > 0) fifo_q.delete(0);
        end
        drive_fifo();
        bus.i_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    endtask

    task automatic push_rec(input int x0, input int y0, input int sx, input int sy);
        rec_t r;
        r.x0 = x0; r.y0 = y0; r.sx = sx; r.sy = sy;
        fifo_q.push_back(r);
        drive_fifo();
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && bus.o_idle && !pop_flag) return;
            step();
        end
        chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic clear_logs();
        beat_x.delete(); beat_y.delete(); beat_id.delete(); beat_last.delete();
        rej_ids.delete(); pop_log.delete();
    endtask

    task automatic chk_beat(input string nm, input int i, input int x, input int y,
                            input int id, input int last);
        if (i >= beat_x.size()) begin
            chk({nm, "_missing"}, beat_x.size(), i + 1);
        end else begin
            chk({nm, "_x"}, beat_x[i], x);
            chk({nm, "_y"}, beat_y[i], y);
            chk({nm, "_id"}, beat_id[i], id);
            chk({nm, "_last"}, beat_last[i], last);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        exp_q.delete();
        model_id = 0;
        pop_flag = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.o_fifo_rd) begin
                chk("rd_while_empty", int'(bus.i_fifo_empty), 0);
                model_pop();
                pop_cyc = cyc;
                pop_log.push_back(cyc);
                pop_flag = 1'b1;
            end
            if (bus.o_reject) begin
                if (exp_q.size() == 0 || !exp_q[0].is_rej) begin
                    chk("unexpected_reject", 1, 0);
                end else begin
                    chk("reject_id", int'(bus.o_tri_id), exp_q[0].id);
                    rej_ids.push_back(int'(bus.o_tri_id));
                    exp_q.delete(0);
                end
            end
            if (bus.o_valid) begin
                if (exp_q.size() == 0 || exp_q[0].is_rej) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("tile_x", int'(bus.o_tile_x), exp_q[0].x);
                    chk("tile_y", int'(bus.o_tile_y), exp_q[0].y);
                    chk("tri_id", int'(bus.o_tri_id), exp_q[0].id);
                    chk("last", int'(bus.o_last), int'(exp_q[0].last));
                    if (exp_q[0].first) begin
                        chk("first_latency", cyc - pop_cyc, 2);
                        exp_q[0].first = 1'b0;
                    end
                    if (bus.i_ready) begin
                        beat_x.push_back(int'(bus.o_tile_x));
                        beat_y.push_back(int'(bus.o_tile_y));
                        beat_id.push_back(int'(bus.o_tri_id));
                        beat_last.push_back(int'(bus.o_last));
                        exp_q.delete(0);
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        bus.i_ready = 1'b1;
        drive_fifo();
        push_rec(4, 4, 0, 0);
        step();
        step();
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_fifo_rd", int'(bus.o_fifo_rd), 0);
        chk("rst_reject", int'(bus.o_reject), 0);
        chk("rst_last", int'(bus.o_last), 0);
        chk("rst_idle", int'(bus.o_idle), 1);
        chk("rst_tile_x", int'(bus.o_tile_x), 0);
        chk("rst_tile_y", int'(bus.o_tile_y), 0);
        fifo_q.delete();
        drive_fifo();
        rst = 1'b0;
        step();

        // Basic 2x2 walk with a ready sink
        clear_logs();
        push_rec(2, 3, 1, 1);
        wait_done("t1", 40);
        chk("t1_pops", pop_log.size(), 1);
        chk("t1_beats", beat_x.size(), 4);
        chk_beat("t1_b0", 0, 2, 3, 0, 0);
        chk_beat("t1_b1", 1, 3, 3, 0, 0);
        chk_beat("t1_b2", 2, 2, 4, 0, 0);
        chk_beat("t1_b3", 3, 3, 4, 0, 1);

        // Same rectangle under a 1,0,0,1 ready pattern
        clear_logs();
        ready_mode = 1;
        push_rec(2, 3, 1, 1);
        wait_done("t2", 60);
        ready_mode = 0;
        chk("t2_beats", beat_x.size(), 4);
        chk_beat("t2_b0", 0, 2, 3, 1, 0);
        chk_beat("t2_b3", 3, 3, 4, 1, 1);

        // Clipped at the right and bottom screen edges
        clear_logs();
        push_rec(18, 29, 5, 4);
        wait_done("t3", 40);
        chk("t3_beats", beat_x.size(), 2);
        chk_beat("t3_b0", 0, 18, 29, 2, 0);
        chk_beat("t3_b1", 1, 19, 29, 2, 1);

        // Off-screen rejects, full-width no-wrap step, last-column single tile
        reset_pulse();
        clear_logs();
        push_rec(25, 0, 0, 0);
        push_rec(0, 0, 65535, 0);
        push_rec(0, 30, 0, 0);
        push_rec(19, 0, 0, 0);
        wait_done("t4", 120);
        chk("t4_rejects", rej_ids.size(), 2);
        if (rej_ids.size() == 2) begin
            chk("t4_rej0_id", rej_ids[0], 0);
            chk("t4_rej1_id", rej_ids[1], 2);
        end
        chk("t4_beats", beat_x.size(), 21);
        chk_beat("t4_b0", 0, 0, 0, 1, 0);
        chk_beat("t4_b19", 19, 19, 0, 1, 1);
        chk_beat("t4_b20", 20, 19, 0, 3, 1);

        // Back-to-back single tiles: id wrap and 3-cycle cadence
        reset_pulse();
        clear_logs();
        for (int i = 0; i < 6; i++) push_rec(i, i, 0, 0);
        wait_done("t5", 60);
        chk("t5_pops", pop_log.size(), 6);
        chk("t5_beats", beat_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < beat_id.size()) chk("t5_id", beat_id[i], t5_ids[i]);
            if (i > 0 && i < pop_log.size()) chk("t5_pop_gap", pop_log[i] - pop_log[i-1], 3);
        end

        // Reset on the third entry of a 3x3 walk
        clear_logs();
        push_rec(0, 0, 2, 2);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_valid && bus.o_tile_x == 16'd2 && bus.o_tile_y == 16'd0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t6_reached_third", int'(found), 1);
        rst = 1'b1;
        exp_q.delete();
        model_id = 0;
        pop_flag = 1'b0;
        #1;
        chk("t6_valid", int'(bus.o_valid), 0);
        chk("t6_idle", int'(bus.o_idle), 1);
        chk("t6_tri_id", int'(bus.o_tri_id), 0);
        push_rec(1, 1, 1, 0);
        step();
        chk("t6_rd_in_reset", int'(bus.o_fifo_rd), 0);
        step();
        clear_logs();
        rst = 1'b0;
        wait_done("t6", 40);
        chk("t6_beats", beat_x.size(), 2);
        chk_beat("t6_b0", 0, 1, 1, 0, 0);
        chk_beat("t6_b1", 1, 2, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ren_bin_walker.md
Name: ren_bin_walker

Overview:
- Reader end of the setup-to-binner triangle queue. The setup stage writes one record per triangle into that queue.
- Pops one record at a time, holding the integer tile base and the tile step counts.
- Clips the tile rectangle to the screen tile grid, then walks it row-major.
- Emits one (tile_x, tile_y, tri_id) bin entry per covered tile over a valid/ready handshake into the per-tile bin list writer.

Parameters:
- NUM_TILES_X, 40, screen width in tiles (must be ≥1).
- NUM_TILES_Y, 30, screen height in tiles (must be ≥1).
- TRI_ID_W, 12, width of the triangle sequence counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_fifo_empty  in  1  queue empty; when low, the head record is valid on i_tile_x0/i_tile_y0/i_steps_x/i_steps_y (first-word fall-through)
- o_fifo_rd  out  1  one-cycle pop strobe; head is consumed on the same edge
- i_tile_x0  in  16  min tile column (unsigned int)
- i_tile_y0  in  16  min tile row
- i_steps_x  in  16  max_col - min_col (inclusive span minus 1)
- i_steps_y  in  16  max_row - min_row
- o_valid  out  1  bin entry valid
- i_ready  in  1  downstream accepts entry
- o_tile_x  out  16  entry column
- o_tile_y  out  16  entry row
- o_tri_id  out  TRI_ID_W  sequence id of the current triangle
- o_last  out  1  final entry of this triangle (qualified by o_valid)
- o_reject  out  1  one-cycle pulse: triangle lies fully off-screen
- o_idle  out  1  walker idle and holds no record

Behaviour:
- Reset (async, rst=1): state s_IDLE, tri_id counter 0, all registers 0.
  - Output values during reset: o_valid=0, o_fifo_rd=0, o_reject=0, o_last=0, o_tile_x/y=0, o_idle=1.
  - Reset mid-walk abandons the triangle; no further pop occurs until after reset deasserts.
- States:
  - s_IDLE: o_idle=1. If !i_fifo_empty, assert o_fifo_rd (combinational, this cycle only), latch all four fields, go to s_CLIP. Otherwise stay.
  - s_CLIP: one cycle, no output.
    - Compute end_x = x0+steps_x and end_y = y0+steps_y in 17 bits, so no wrap.
    - If x0 ≥ NUM_TILES_X or y0 ≥ NUM_TILES_Y: pulse o_reject, increment tri_id, return to s_IDLE.
    - Otherwise clamp end_x to min(end_x, NUM_TILES_X-1) and end_y to min(end_y, NUM_TILES_Y-1), set cur=(x0,y0), go to s_WALK.
  - s_WALK: o_valid=1 and o_tile_x/y = cur. A beat completes on the edge where o_valid & i_ready.
    - If cur_x≠end_x: cur_x++.
    - Else if cur_y≠end_y: cur_x=x0, cur_y++.
    - Else (o_last=1 on this beat): increment tri_id, go to s_IDLE.
- Handshake rules:
  - o_valid never depends on i_ready.
  - While o_valid=1 and i_ready=0, o_tile_x, o_tile_y, o_tri_id and o_last hold stable.
  - Entries are in row-major order, x fastest.
- Latency:
  - Pop cycle T → first o_valid at T+2.
  - With i_ready held at 1: one entry per cycle, and the next pop occurs the cycle after the o_last beat.
  - Total per triangle = tiles + 2 cycles.
- tri_id is incremented for both rejected and walked triangles, and wraps modulo 2^TRI_ID_W.
- A single-tile triangle (steps 0,0) gives one beat with o_last=1.
- o_fifo_rd is never asserted outside s_IDLE, and never while i_fifo_empty=1.

Decomposition:
- Shared package (ren_params): NUM_TILES_X/NUM_TILES_Y defaults, TILE_SIZE, state encodings s_IDLE/s_CLIP/s_WALK, and the record field widths.
- Sub-module ren_tile_clamp (combinational): 16-bit base + 16-bit step → 17-bit end, clamped to limit-1, plus an off-screen flag. One instance each for x and y.
- Everything else stays in a single module.

Test Plan:
- Record x0=2,y0=3,sx=1,sy=1, i_ready=1 → o_fifo_rd one pulse.
  - Entries (2,3),(3,3),(2,4),(3,4) on consecutive cycles, o_last only on (3,4), tri_id=0, first o_valid 2 cycles after the pop.
- Same record with i_ready toggling 1,0,0,1,… → outputs held stable while stalled, same 4 entries in the same order, no duplicates or drops.
- NUM_TILES_X=20,NUM_TILES_Y=30: x0=18,y0=29,sx=5,sy=4 → exactly (18,29),(19,29), o_last on (19,29).
- x0=25,y0=0 (NUM_TILES_X=20) → no o_valid, o_reject one pulse, next triangle carries tri_id=1. Also steps=0xFFFF at x0=0 → clamped to 0..19 with no wrap.
- TRI_ID_W=2, six back-to-back single-tile records with FIFO non-empty → tri_ids 0,1,2,3,0,1, one pop per triangle, 3 cycles per triangle.
- Assert rst on the 3rd entry of a 3×3 walk → o_valid=0 immediately, tri_id=0, o_idle=1. After release, the next record is popped and walked from its start.
